// File: rtl/tug_pkg.sv
// Shared types and constants for the tug-of-war playfield: FSM states, display modes, centre index.
// No logic of its own; zero latency.
// No flow control; constants only.
package tug_pkg;

    typedef enum logic [1:0] {
        ST_WAIT  = 2'd0,
        ST_RACE  = 2'd1,
        ST_SCORE = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    localparam logic [1:0] LED_POS  = 2'b00;
    localparam logic [1:0] LED_OFF  = 2'b01;
    localparam logic [1:0] LED_ON   = 2'b10;
    localparam logic [1:0] LED_HALF = 2'b11;

    function automatic int center_idx(input int n);
        return (n - 1) / 2;
    endfunction

endpackage

// File: rtl/tug_playfield_pb_sync.sv
// Push-button synchronizer plus rising-edge detector producing a one-cycle press pulse.
// Latency: press fires 1 cycle after the last synchronizer stage rises.
// No backpressure; a button already held when reset ends is ignored until it is seen released.
module pb_sync #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic pb,
    output logic press
);

    logic [SYNC_STAGES-1:0] sync;
    logic                   prev;
    logic                   armed;
    logic [1:0]             fill;

    // fill counts edges until the chain holds only post-reset samples; only then may it arm
    always_ff @(posedge clk) begin
        if (rst) begin
            sync  <= '0;
            prev  <= 1'b0;
            armed <= 1'b0;
            fill  <= 2'd0;
            press <= 1'b0;
        end else begin
            sync  <= {sync[SYNC_STAGES-2:0], pb};
            prev  <= sync[SYNC_STAGES-1];
            press <= sync[SYNC_STAGES-1] & ~prev & armed;
            if (fill != 2'(SYNC_STAGES)) begin
                fill <= fill + 2'd1;
            end else if (!sync[SYNC_STAGES-1]) begin
                armed <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/tug_playfield.sv
// Tug-of-war playfield: button race FSM moving a marker, LED display. Optional TUG_FALSE_START_EN.
// Latency: press event -> pos on next edge; winrnd and leds one cycle after that.
// No backpressure; events arriving outside the race window are dropped.
module tug_playfield
    import tug_pkg::*;
#(
    parameter int NLED        = 7,
    parameter int SYNC_STAGES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            clear,
    input  logic            leds_on,
    input  logic [1:0]      led_control,
    input  logic            pbl,
    input  logic            pbr,
    output logic [NLED-1:0] leds,
    output logic            winrnd,
    output logic            gameover
);

    localparam int            C       = center_idx(NLED);
    localparam int            PW      = $clog2(NLED);
    localparam logic [PW-1:0] POS_C   = PW'(C);
    localparam logic [PW-1:0] POS_MAX = PW'(NLED - 1);

    state_t        state;
    logic [PW-1:0] pos;
    logic [PW-1:0] pos_inc;
    logic [PW-1:0] pos_dec;
    logic          press_l;
    logic          press_r;

    pb_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_l (
        .clk   (clk),
        .rst   (rst),
        .pb    (pbl),
        .press (press_l)
    );

    pb_sync #(.SYNC_STAGES(SYNC_STAGES)) u_sync_r (
        .clk   (clk),
        .rst   (rst),
        .pb    (pbr),
        .press (press_r)
    );

    assign pos_inc = (pos == POS_MAX) ? pos : pos + 1'b1;
    assign pos_dec = (pos == '0)      ? pos : pos - 1'b1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_WAIT;
            pos      <= POS_C;
            winrnd   <= 1'b0;
            gameover <= 1'b0;
        end else begin
            winrnd <= 1'b0;
            case (state)
                ST_WAIT: begin
                    if (clear) begin
                        state <= ST_RACE;
`ifdef TUG_FALSE_START_EN
                    // a lone early press hands the step to the opponent
                    end else if (press_l ^ press_r) begin
                        pos   <= press_l ? pos_inc : pos_dec;
                        state <= ST_SCORE;
`endif
                    end
                end
                ST_RACE: begin
                    if (press_l || press_r) begin
                        state <= ST_SCORE;
                        if (press_l && !press_r) begin
                            pos <= pos_dec;
                        end else if (press_r && !press_l) begin
                            pos <= pos_inc;
                        end
                    end
                end
                ST_SCORE: begin
                    winrnd <= 1'b1;
                    if (pos == '0 || pos == POS_MAX) begin
                        state    <= ST_OVER;
                        gameover <= 1'b1;
                    end else begin
                        state <= ST_WAIT;
                    end
                end
                ST_OVER: begin
                    gameover <= 1'b1;
                end
                default: state <= ST_WAIT;
            endcase
        end
    end

    function automatic logic [NLED-1:0] led_map(input logic [PW-1:0] p,
                                                input logic [1:0]    mode,
                                                input logic          en);
        logic [NLED-1:0] m;
        m = '0;
        case (mode)
            LED_POS:  m[p] = 1'b1;
            LED_OFF:  m = '0;
            LED_ON:   m = '1;
            LED_HALF: begin
                for (int i = 0; i < NLED; i++) begin
                    if (p < POS_C)      m[i] = (i <= C);
                    else if (p > POS_C) m[i] = (i >= C);
                    else                m[i] = (i == C);
                end
            end
            default:  m = '0;
        endcase
        return en ? m : '0;
    endfunction

    always_ff @(posedge clk) begin
        if (rst) begin
            leds <= led_map(POS_C, led_control, leds_on);
        end else begin
            leds <= led_map(pos, led_control, leds_on);
        end
    end

endmodule
